// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder modelling the accelerometer end of the SPI link.
// Frames are a command byte {rw, mb, addr[5:0]} followed by data bytes,
// served from a 64x8 register bank. Host-side X/Y/Z samples land in
// 0x32..0x37 and raise DATA_READY (INT_SOURCE bit 7).
// Ports:
//   clk, reset            system clock (>= 8x SPI_CLK), synchronous active-high reset
//   sample_valid, sample_x/y/z  host sample strobe and 16-bit samples
//   SPI_CLK, SPI_CSN, SPI_SDI   asynchronous SPI inputs from the master
//   SPI_SDO               read data to the master (driven low when not reading)
//   interrupt             {INT2, INT1}, DATA_READY routed by INT_MAP bit 7
//   wr_strobe, wr_addr, wr_data  one-cycle notification of a committed write
module spi_accel_responder #(
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        SPI_CLK,
  input  logic        SPI_CSN,
  input  logic        SPI_SDI,
  output logic        SPI_SDO,
  output logic [1:0]  interrupt,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam int unsigned NUM_REGS  = 64;
  localparam logic [5:0] ADDR_RATE    = 6'h2C;
  localparam logic [5:0] ADDR_INT_EN  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP = 6'h2F;
  localparam logic [5:0] ADDR_INT_SRC = 6'h30;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
  logic sclk_s, csn_s, sdi_s, sclk_d, csn_d;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise;

  logic [2:0]  bit_cnt;
  logic [7:0]  rx, tx, rx_byte;
  logic        rw, mb, byte_done;
  logic [5:0]  addr, addr_next;
  logic [7:0]  regs [NUM_REGS];

  logic        pend_valid;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        data_ready_irq;

  function automatic logic is_read_only(input logic [5:0] a);
    return (a == 6'h00) || (a == ADDR_INT_SRC) || (a >= 6'h32 && a <= 6'h37);
  endfunction

  // Synchronizers and edge-history flops; left unreset so a reset with CSN held
  // low cannot manufacture a CSN falling edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
    csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSN};
    sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SPI_SDI};
    sclk_d    <= sclk_s;
    csn_d     <= csn_s;
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign csn_rise  = csn_s & ~csn_d;

  assign rx_byte   = {rx[6:0], sdi_s};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7) & ~csn_rise;
  assign addr_next = mb ? addr + 6'd1 : addr;
  assign data_ready_irq = regs[ADDR_INT_SRC][7] & regs[ADDR_INT_EN][7];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; CSN deassertion aborts from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csn_fall) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = DATA;
      DATA:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
    if (csn_rise) state_nxt = IDLE;
  end

  // Shift datapath, register bank, sample loading and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      rw         <= 1'b0;
      mb         <= 1'b0;
      addr       <= '0;
      SPI_SDO    <= 1'b0;
      interrupt  <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[0]         <= DEVID;
      regs[ADDR_RATE] <= 8'h0A;
    end else begin
      wr_strobe <= 1'b0;
      interrupt <= regs[ADDR_INT_MAP][7] ? {data_ready_irq, 1'b0} : {1'b0, data_ready_irq};

      case (state)
        IDLE: begin
          if (csn_fall) begin
            bit_cnt <= '0;
            rx      <= '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx      <= rx_byte;
          end
          if (byte_done) begin
            rw   <= rx_byte[7];
            mb   <= rx_byte[6];
            addr <= rx_byte[5:0];
            tx   <= regs[rx_byte[5:0]];
          end
        end
        DATA: begin
          if (sclk_fall && rw) begin
            SPI_SDO <= tx[7];
            tx      <= {tx[6:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx      <= rx_byte;
          end
          if (byte_done) begin
            if (!rw && !is_read_only(addr)) begin
              regs[addr] <= rx_byte;
              wr_strobe  <= 1'b1;
              wr_addr    <= addr;
              wr_data    <= rx_byte;
            end
            if (rw && addr == ADDR_INT_SRC) regs[ADDR_INT_SRC] <= 8'h00;
            addr <= addr_next;
            if (rw) tx <= regs[addr_next];
          end
        end
        default: ;
      endcase

      if (state != DATA || !rw || csn_rise) SPI_SDO <= 1'b0;

      // Samples only land while idle; a transfer sees one consistent sample.
      // Placed last so a DATA_READY set beats a same-cycle clear.
      if (state == IDLE) begin
        if (sample_valid || pend_valid) begin
          regs[6'h32] <= sample_valid ? sample_x[7:0]  : pend_x[7:0];
          regs[6'h33] <= sample_valid ? sample_x[15:8] : pend_x[15:8];
          regs[6'h34] <= sample_valid ? sample_y[7:0]  : pend_y[7:0];
          regs[6'h35] <= sample_valid ? sample_y[15:8] : pend_y[15:8];
          regs[6'h36] <= sample_valid ? sample_z[7:0]  : pend_z[7:0];
          regs[6'h37] <= sample_valid ? sample_z[15:8] : pend_z[15:8];
          regs[ADDR_INT_SRC] <= 8'h80;
        end
        pend_valid <= 1'b0;
      end else if (sample_valid) begin
        pend_valid <= 1'b1;
        pend_x     <= sample_x;
        pend_y     <= sample_y;
        pend_z     <= sample_z;
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Self-checking bench for spi_accel_responder: bit-banged SPI mode-3 master,
// a small register model feeding expected-read and expected-write queues.
module tb_spi_accel_responder;

  localparam time HALF = 80ns;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        SPI_CLK = 1'b1, SPI_CSN = 1'b1, SPI_SDI = 1'b0;
  logic        SPI_SDO;
  logic [1:0]  interrupt;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  logic [7:0]  model [64];
  logic [7:0]  rd_q [$];
  logic [13:0] wr_q [$];

  spi_accel_responder dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .SPI_CLK(SPI_CLK), .SPI_CSN(SPI_CSN), .SPI_SDI(SPI_SDI), .SPI_SDO(SPI_SDO),
    .interrupt(interrupt), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5ns clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ro(input logic [5:0] a);
    return (a == 6'h00) || (a == 6'h30) || (a >= 6'h32 && a <= 6'h37);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    model[0]     = 8'hE5;
    model[6'h2C] = 8'h0A;
  endtask

  task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    model[6'h32] = x[7:0]; model[6'h33] = x[15:8];
    model[6'h34] = y[7:0]; model[6'h35] = y[15:8];
    model[6'h36] = z[7:0]; model[6'h37] = z[15:8];
    model[6'h30] = 8'h80;
  endtask

  // Write-notification scoreboard
  always @(negedge clk) begin
    if (!reset && wr_strobe) begin
      strobe_cnt++;
      if (wr_q.size() == 0) check_eq("wr_unexpected", 1, 0);
      else check_eq("wr_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, wr_q.pop_front()});
    end
  end

  task automatic xfer_bits(input logic [7:0] mosi, input int n, output logic [7:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      SPI_CLK = 1'b0;
      SPI_SDI = mosi[7-i];
      #(HALF);
      miso = {miso[6:0], SPI_SDO};
      SPI_CLK = 1'b1;
      #(HALF);
    end
  endtask

  task automatic cs_low();
    SPI_CSN = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    SPI_CSN = 1'b1;
    #(2*HALF);
  endtask

  task automatic pop_read(input logic [7:0] got);
    if (rd_q.size() == 0) check_eq("rd_underflow", 1, 0);
    else check_eq("rd_data", {24'd0, got}, {24'd0, rd_q.pop_front()});
  endtask

  task automatic push_reads(input logic [5:0] addr, input int n, input logic mb);
    logic [5:0] a;
    a = addr;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(model[a]);
      if (a == 6'h30) model[a] = 8'h00;
      if (mb) a = a + 6'd1;
    end
  endtask

  task automatic spi_read(input logic [5:0] addr, input int n, input logic mb);
    logic [7:0] got;
    push_reads(addr, n, mb);
    cs_low();
    xfer_bits({1'b1, mb, addr}, 8, got);
    for (int i = 0; i < n; i++) begin
      xfer_bits(8'h00, 8, got);
      pop_read(got);
    end
    cs_high();
  endtask

  task automatic spi_write(input logic [5:0] addr, input logic [7:0] data);
    logic [7:0] got;
    if (!ro(addr)) begin
      wr_q.push_back({addr, data});
      model[addr] = data;
      exp_strobes++;
    end
    cs_low();
    xfer_bits({2'b00, addr}, 8, got);
    xfer_bits(data, 8, got);
    cs_high();
    check_eq("wr_count", strobe_cnt, exp_strobes);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] got;
    model_reset();
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_sdo", SPI_SDO, 0);
    check_eq("rst_int", interrupt, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);

    // ID and default registers
    spi_read(6'h00, 1, 1'b0);
    spi_read(6'h2C, 1, 1'b0);

    // Plain write then readback
    spi_write(6'h24, 8'h20);
    spi_read(6'h24, 1, 1'b0);

    // Sample load, burst read, DATA_READY read-to-clear
    pulse_sample(16'h0123, 16'hFF80, 16'h7FFF);
    model_sample(16'h0123, 16'hFF80, 16'h7FFF);
    spi_read(6'h32, 6, 1'b1);
    spi_read(6'h30, 1, 1'b0);
    spi_read(6'h30, 1, 1'b0);

    // New sample mid-burst stays pending until CSN rises
    push_reads(6'h32, 6, 1'b1);
    cs_low();
    xfer_bits(8'hF2, 8, got);
    for (int i = 0; i < 6; i++) begin
      xfer_bits(8'h00, 8, got);
      pop_read(got);
      if (i == 1) pulse_sample(16'h4321, 16'h8765, 16'hCBA9);
    end
    cs_high();
    model_sample(16'h4321, 16'h8765, 16'hCBA9);
    spi_read(6'h32, 6, 1'b1);

    // Read-only writes ignored
    spi_write(6'h00, 8'h55);
    spi_write(6'h33, 8'h55);
    spi_read(6'h00, 1, 1'b0);
    spi_read(6'h33, 1, 1'b0);

    // Aborted write after 4 data bits
    cs_low();
    xfer_bits(8'h25, 8, got);
    xfer_bits(8'hFF, 4, got);
    cs_high();
    check_eq("partial_wr_count", strobe_cnt, exp_strobes);
    spi_read(6'h25, 1, 1'b0);

    // Address wrap 0x3F -> 0x00 on a multi-byte read
    spi_read(6'h3F, 2, 1'b1);

    // DATA_READY routed to INT2
    spi_write(6'h2E, 8'h80);
    spi_write(6'h2F, 8'h80);
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    model_sample(16'h1111, 16'h2222, 16'h3333);
    check_eq("int_mapped", interrupt, 2'b10);
    spi_read(6'h30, 1, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("int_cleared", interrupt, 2'b00);

    // Reset in the middle of a write: no commit, block returns to defaults
    cs_low();
    xfer_bits(8'h24, 8, got);
    xfer_bits(8'hAA, 4, got);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_eq("midrst_sdo", SPI_SDO, 0);
    check_eq("midrst_wr_addr", wr_addr, 0);
    xfer_bits(8'hA0, 4, got);
    check_eq("midrst_sdo_idle", SPI_SDO, 0);
    cs_high();
    check_eq("midrst_wr_count", strobe_cnt, exp_strobes);
    spi_read(6'h24, 1, 1'b0);
    spi_read(6'h2C, 1, 1'b0);
    spi_read(6'h00, 1, 1'b0);

    check_eq("wr_q_drained", wr_q.size(), 0);
    check_eq("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
- Synthesizable SPI responder that models the accelerometer end of our SPI link. It uses the same 16-bit command/data framing the accelerometer controller drives: R/W, MB, 6-bit address, then data bytes.
- Holds a 64x8 register bank. Serves register reads and writes from the SPI master, and exposes X/Y/Z samples loaded from a host-side port.
- Used as an on-board loopback target and as a bench model for the accelerometer controller.

Parameters:
- DEVID, 8'hE5, value returned at address 0x00 (read-only).
- SYNC_STAGES, 2, synchronizer depth on SPI_CLK, SPI_CSN and SPI_SDI (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SPI_CLK frequency.
- reset  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; sample_x/y/z are valid.
- sample_x  input  16  X sample, two's complement.
- sample_y  input  16  Y sample.
- sample_z  input  16  Z sample.
- SPI_CLK  input  1  SPI clock from master, mode 3 (CPOL=1, CPHA=1).
- SPI_CSN  input  1  chip select, active low.
- SPI_SDI  input  1  master-to-responder data.
- SPI_SDO  output  1  responder-to-master data.
- interrupt  output  2  active-high interrupt pins INT1 (bit 0) and INT2 (bit 1).
- wr_strobe  output  1  one-cycle pulse when a register write commits.
- wr_addr  output  6  address of the committed write.
- wr_data  output  8  data of the committed write.

Behaviour:
- Reset values:
  - SPI_SDO=0, interrupt=0, wr_strobe=0, wr_addr=0, wr_data=0, FSM=IDLE, pending buffer empty.
  - All registers 0 except 0x00=DEVID and 0x2C=8'h0A.
- Input sync and edge detect:
  - SPI_CLK, SPI_CSN and SPI_SDI pass through SYNC_STAGES flops.
  - Rise, fall and CSN edges are detected on the synchronized copies; latency is SYNC_STAGES+1 clk cycles.
- FSM:
  - IDLE -> CMD on synchronized CSN falling edge; clears bit_cnt (3 bits) and the rx shift register.
  - CMD: each SCLK rise shifts SDI into rx (MSB first). On the 8th rise, latch rw=bit7, mb=bit6, addr=bits5:0. For a read, load tx=reg[addr]. Go to DATA.
  - DATA:
    - Each SCLK fall drives SPI_SDO=tx[7] and then shifts tx left; the first fall after CMD presents bit 7.
    - Each SCLK rise shifts SDI into rx.
    - On the 8th rise, a write commits reg[addr]<=rx unless addr is read-only, and pulses wr_strobe with addr/data the next cycle.
    - Also on the 8th rise: if mb=1, addr<=addr+1 with wrap 0x3F->0x00; if mb=0, addr is unchanged. For a read, tx is reloaded from the (new) addr.
  - Any state -> IDLE on synchronized CSN rising edge. A partial byte is discarded (no commit, no wr_strobe). SPI_SDO returns to 0.
- SPI_SDO is 0 whenever the FSM is not in DATA with rw=1. No tristate.
- Read-only addresses: 0x00, 0x30, and 0x32..0x37. Writes to these are ignored, and wr_strobe does not pulse.
- Sample loading:
  - When sample_valid=1 and the FSM is IDLE (CSN high), copy the samples into 0x32..0x37 the next cycle. Mapping: 0x32=x[7:0], 0x33=x[15:8], 0x34=y[7:0], 0x35=y[15:8], 0x36=z[7:0], 0x37=z[15:8]. Set INT_SOURCE (0x30) bit 7 (DATA_READY).
  - When CSN is low, the samples go into the pending buffer, and a newer sample overwrites the pending one. The buffer is applied on the cycle after the CSN rising edge, so a read burst never mixes two samples.
- INT_SOURCE bit 7:
  - Cleared when a read byte of address 0x30 completes (8th rise).
  - If a set and a clear happen in the same cycle, the set wins.
  - All other INT_SOURCE bits read 0.
- Interrupts: dr = INT_SOURCE[7] & INT_ENABLE(0x2E)[7]. The registered output gives interrupt[1]=dr when INT_MAP(0x2F)[7]=1, otherwise interrupt[0]=dr.
- Reset asserted mid-transaction returns the block to reset values the next clk edge. It stays in IDLE until a fresh CSN falling edge.

Test Plan:
- Reset, then read 0x00 with MB=0 -> SDO shifts 8'hE5. Read 0x2C -> 8'h0A.
- Write 0x24=8'h20 (frame 16'h2420) -> wr_strobe=1 once with wr_addr=6'h24, wr_data=8'h20. A later read of 0x24 returns 8'h20.
- Apply sample x=16'h0123, y=16'hFF80, z=16'h7FFF, then do a MB read from 0x32 with 6 data bytes -> 23,01,80,FF,FF,7F. INT_SOURCE reads 8'h80, and a second read of it returns 8'h00.
- Start a MB read of 0x32, pulse a new sample after the 2nd byte -> all 6 bytes are the old sample. After CSN high, the new values read back.
- Write 8'h55 to 0x00 and to 0x33 -> no wr_strobe, and the values are unchanged. Raise CSN after 4 data bits of a write to 0x25 -> 0x25 is unchanged and there is no wr_strobe.
- Write INT_ENABLE=8'h80 and INT_MAP=8'h80, then pulse a sample -> interrupt=2'b10. Reading 0x30 -> interrupt=2'b00.
